// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and defaults for the two-master data memory arbiter.
package dmem_arb_pkg;
   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
   typedef logic midx_t;
   localparam int BURST_MAX_DEF = 4;
endpackage

// File: rtl/rr_select.sv
// rr_select: two-way round-robin picker; on a tie the master that did not own last wins.
module rr_select (
   input  logic req0,
   input  logic req1,
   input  logic last_owner,
   output logic win
);
   assign win = req1 & (~req0 | ~last_owner);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: grants one of two masters access to a single-port data memory,
// limiting bursts to BURST_MAX beats while the other master is waiting.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int BURST_MAX = BURST_MAX_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0,
   input  logic        req1,
   input  logic        we0,
   input  logic        we1,
   input  logic [31:0] a0,
   input  logic [31:0] a1,
   input  logic [31:0] wd0,
   input  logic [31:0] wd1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        rvalid0,
   output logic        rvalid1,
   output logic [31:0] rdata,
   output logic        mem_we,
   output logic [31:0] mem_a,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd
);
   localparam int CW = $clog2(BURST_MAX + 1);
   state_t        state, next_state;
   logic [CW-1:0] cnt, next_cnt;
   midx_t         last_owner, next_last, win;
   logic          own, req_x, req_y, last_hit, rd0, rd1;

   rr_select u_rr (
      .req0       (req0),
      .req1       (req1),
      .last_owner (last_owner),
      .win        (win)
   );

   assign rd0 = gnt0 & ~we0;
   assign rd1 = gnt1 & ~we1;

   always_comb begin
      own        = state == OWN1;
      req_x      = own ? req1 : req0;
      req_y      = own ? req0 : req1;
      gnt0       = (state == OWN0) & req0;
      gnt1       = (state == OWN1) & req1;
      mem_we     = (gnt0 & we0) | (gnt1 & we1);
      mem_a      = (state == OWN0) ? a0 : (state == OWN1) ? a1 : '0;
      mem_wd     = (state == OWN0) ? wd0 : (state == OWN1) ? wd1 : '0;
      last_hit   = cnt == CW'(BURST_MAX - 1);
      next_state = state;
      next_cnt   = cnt;
      next_last  = last_owner;
      if (state == IDLE) begin
         if (req0 | req1) next_state = win ? OWN1 : OWN0;
      end else if (!req_x) begin
         next_state = !req_y ? IDLE : own ? OWN0 : OWN1;
         next_last  = own;
      end else if (last_hit & req_y) begin
         next_state = own ? OWN0 : OWN1;
         next_last  = own;
      end else begin
         // an uncontested owner keeps going; the count just wraps
         next_cnt = last_hit ? '0 : cnt + 1'b1;
      end
      if (next_state != state) next_cnt = '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         cnt        <= '0;
         last_owner <= 1'b1;
         rvalid0    <= 1'b0;
         rvalid1    <= 1'b0;
         rdata      <= '0;
      end else begin
         state      <= next_state;
         cnt        <= next_cnt;
         last_owner <= next_last;
         rvalid0    <= rd0;
         rvalid1    <= rd1;
         if (rd0 | rd1) rdata <= mem_rd;
      end
   end
endmodule
